// File: rtl/pe_sequencer.sv
// Command/data sequencer that produces registered mode, operand and activate drive for a PE.
// Define PE_SEQUENCER_STAT_EN to add the stall_cnt starvation counter output.
module pe_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    input  logic [DATA_W-1:0] din_aux,
    output logic [DATA_W-1:0] pe_in,
    output logic [DATA_W-1:0] pe_filter,
    output logic [1:0]        pe_mode,
    output logic              pe_activate,
    output logic              busy,
`ifdef PE_SEQUENCER_STAT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done
);

    localparam logic [1:0] ModeSingle = 2'd0;
    localparam logic [1:0] ModeSa     = 2'd1;
    localparam logic [1:0] ModeSave   = 2'd2;
    localparam logic [1:0] ModeInit   = 2'd3;
    localparam logic [LEN_W:0] CntOne = {{LEN_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StSingle, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             active, beat, cmd_fire;
    logic [1:0]       mode_d;
    logic             act_d;

    assign active = (state_q == StLoad) || (state_q == StRun) || (state_q == StSingle);

    // Handshakes are suppressed during reset so nothing is consumed in that cycle.
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign din_ready = active && (cnt_q < {1'b0, len_q}) && !rst;
    assign beat      = din_valid && din_ready;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    cnt_d = '0;
                    len_d = cmd_len;
                    if (cmd_op == 2'd3 || cmd_len == '0) begin
                        state_d = StDone;
                    end else if (cmd_op == 2'd0) begin
                        state_d = StLoad;
                    end else if (cmd_op == 2'd1) begin
                        state_d = StRun;
                    end else begin
                        state_d = StSingle;
                    end
                end
            end
            StLoad, StRun, StSingle: begin
                if (beat) begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_d == {1'b0, len_q}) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d = ModeInit;
        act_d  = 1'b0;
        if (beat) begin
            unique case (state_q)
                StLoad:   mode_d = ModeSave;
                StRun: begin
                    mode_d = ModeSa;
                    act_d  = 1'b1;
                end
                StSingle: mode_d = ModeSingle;
                default:  mode_d = ModeInit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            pe_in       <= '0;
            pe_filter   <= '0;
            pe_mode     <= ModeInit;
            pe_activate <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            pe_mode     <= mode_d;
            pe_activate <= act_d;
            // Operands hold their last value whenever no beat is accepted.
            if (beat) begin
                pe_in     <= din_data;
                pe_filter <= din_aux;
            end
        end
    end

`ifdef PE_SEQUENCER_STAT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || cmd_fire) begin
            stall_q <= '0;
        end else if (din_ready && !din_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized and directed bench for pe_sequencer against a transaction-level reference model.
// Also exercises stall_cnt when built with PE_SEQUENCER_STAT_EN.
module tb_pe_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] din_data;
    logic [7:0] din_aux;
    logic [7:0] pe_in;
    logic [7:0] pe_filter;
    logic [1:0] pe_mode;
    logic       pe_activate;
    logic       busy;
    logic       done;
`ifdef PE_SEQUENCER_STAT_EN
    logic [15:0] stall_cnt;
`endif

    pe_sequencer #(.DATA_W(8), .LEN_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din_data    (din_data),
        .din_aux     (din_aux),
        .pe_in       (pe_in),
        .pe_filter   (pe_filter),
        .pe_mode     (pe_mode),
        .pe_activate (pe_activate),
        .busy        (busy),
`ifdef PE_SEQUENCER_STAT_EN
        .stall_cnt   (stall_cnt),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: phase 0 = waiting for a command, 1 = collecting beats, 2 = completion cycle.
    int         m_phase = 0;
    int         m_left  = 0;
    int         m_op    = 0;
    int         m_stall = 0;
    logic [1:0] e_mode  = 2'd3;
    logic       e_act   = 1'b0;
    logic [7:0] e_in    = 8'd0;
    logic [7:0] e_filt  = 8'd0;

    task automatic step(input logic r, input logic cv, input logic [1:0] op, input logic [7:0] len,
                        input logic dv, input logic [7:0] d, input logic [7:0] a);
        bit beat;
        @(posedge clk);
        #1;
        check("pe_mode", 32'(pe_mode), 32'(e_mode));
        check("pe_activate", 32'(pe_activate), 32'(e_act));
        check("pe_in", 32'(pe_in), 32'(e_in));
        check("pe_filter", 32'(pe_filter), 32'(e_filt));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_phase == 2));
`ifdef PE_SEQUENCER_STAT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        rst = r; cmd_valid = cv; cmd_op = op; cmd_len = len;
        din_valid = dv; din_data = d; din_aux = a;
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0 && !r));
        check("din_ready", 32'(din_ready), 32'(m_phase == 1 && m_left > 0 && !r));
        if (r) begin
            m_phase = 0; m_left = 0; m_stall = 0;
            e_mode = 2'd3; e_act = 1'b0; e_in = 8'd0; e_filt = 8'd0;
        end else begin
            beat = dv && m_phase == 1;
            if (beat) begin
                e_in   = d;
                e_filt = a;
                e_mode = (m_op == 0) ? 2'd2 : (m_op == 1) ? 2'd1 : 2'd0;
                e_act  = (m_op == 1);
            end else begin
                e_mode = 2'd3;
                e_act  = 1'b0;
            end
            case (m_phase)
                0: if (cv) begin
                    m_stall = 0;
                    m_op    = int'(op);
                    m_left  = int'(len);
                    m_phase = (op == 2'd3 || len == 8'd0) ? 2 : 1;
                end
                1: begin
                    if (!dv && m_stall < 65535) m_stall++;
                    if (beat) begin
                        m_left--;
                        if (m_left == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic beat_in(input logic [7:0] d, input logic [7:0] a);
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, d, a);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] len);
        step(1'b0, 1'b1, op, len, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 8'd0;
        din_valid = 1'b0; din_data = 8'd0; din_aux = 8'd0;
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        idle(1);

        // Reset held two cycles in the middle of a RUN with beats offered.
        cmd(2'd1, 8'd5);
        beat_in(8'h09, 8'h19);
        beat_in(8'h08, 8'h18);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 8'h07, 8'h17);
        step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 8'h06, 8'h16);
        idle(2);

        cmd(2'd0, 8'd1);
        beat_in(8'h00, 8'h05);
        idle(2);

        cmd(2'd1, 8'd3);
        beat_in(8'd2, 8'd1);
        beat_in(8'd3, 8'd4);
        beat_in(8'd4, 8'd0);
        idle(2);

        cmd(2'd1, 8'd2);
        beat_in(8'h11, 8'h22);
        idle(2);
        beat_in(8'h33, 8'h44);
        idle(2);

        cmd(2'd2, 8'd4);
        for (int i = 1; i <= 4; i++) beat_in(8'(i), 8'd3);
        idle(2);

        // Zero-length and NOP commands, with data offered that must not be taken.
        step(1'b0, 1'b1, 2'd1, 8'd0, 1'b1, 8'hAA, 8'hBB);
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 8'hAA, 8'hBB);
        step(1'b0, 1'b1, 2'd3, 8'd4, 1'b1, 8'hCC, 8'hDD);
        step(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 8'hCC, 8'hDD);
        idle(2);

        // Maximum length, with command lines toggling while busy.
        cmd(2'd0, 8'd255);
        for (int i = 0; i < 255; i++)
            step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 1'b1, 8'(i), 8'(255 - i));
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom),
                 8'($urandom_range(0, 6)), ($urandom_range(0, 9) < 7),
                 8'($urandom), 8'($urandom));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Upstream stage of the PE: converts a command stream plus a data stream into the per-cycle mode/pe_in/pe_filter/activate drive that a PE (or the head of a PE chain) consumes.
- Commands select one of three operations:
  - weight load (save mode)
  - systolic run (sa mode)
  - single-PE multiply-accumulate (single mode)
- When idle or starved, it drives initial mode so the PE holds its state.
- All PE-facing outputs are registered.

Parameters:
- DATA_W, 8, width of pe_in / pe_filter / data-stream fields
- LEN_W, 8, width of the command beat-count field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer accepts command (high only in IDLE)
- cmd_op  in  2  0=LOAD, 1=RUN, 2=SINGLE, 3=reserved (treated as NOP)
- cmd_len  in  LEN_W  number of data beats for the command
- din_valid  in  1  data beat offered
- din_ready  out  1  data beat accepted when din_valid&din_ready
- din_data  in  DATA_W  value for PE pe_in
- din_aux  in  DATA_W  value for PE pe_filter (weight or addend)
- pe_in  out  DATA_W  to PE pe_in
- pe_filter  out  DATA_W  to PE pe_filter
- pe_mode  out  2  to PE mode_i: 0 single, 1 sa, 2 save, 3 initial
- pe_activate  out  1  to PE activate
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - state=IDLE, beat counter=0
  - pe_in=0, pe_filter=0, pe_mode=3, pe_activate=0, done=0, busy=0
  - Reset mid-command abandons the command; any beat presented in that cycle is not consumed.
- States: IDLE, LOAD, RUN, SINGLE, DONE.
- IDLE:
  - cmd_ready=1, din_ready=0.
  - On cmd_valid, latch cmd_op and cmd_len, then go to LOAD/RUN/SINGLE per op.
  - op=3 or cmd_len=0: go directly to DONE; no beats are consumed.
- Active states (LOAD/RUN/SINGLE):
  - din_ready=1 while the counter < latched len.
  - Each accepted beat increments the counter.
  - When the beat that makes counter==len is accepted, go to DONE.
- Output register, updated every cycle; one-cycle latency from beat acceptance to the PE pins:
  - Accepted beat in LOAD: pe_mode=2, pe_filter=din_aux, pe_in=din_data, pe_activate=0.
  - Accepted beat in RUN: pe_mode=1, pe_in=din_data, pe_filter=din_aux, pe_activate=1.
  - Accepted beat in SINGLE: pe_mode=0, pe_in=din_data, pe_filter=din_aux, pe_activate=0.
  - No accepted beat (starvation, IDLE, DONE): pe_mode=3, pe_activate=0; pe_in and pe_filter hold their previous values.
- DONE:
  - Lasts exactly one cycle: done=1, cmd_ready=0, din_ready=0; then return to IDLE.
  - done is asserted in the same cycle the last beat appears on the PE pins.
  - For a zero-length or NOP command, done is asserted the cycle after acceptance.
- Back-to-back commands: the minimum gap between commands is the DONE cycle plus the IDLE acceptance cycle.
- Counter width is LEN_W+1, so it never wraps; cmd_len=2^LEN_W-1 is fully supported.
- din_valid while in IDLE/DONE is ignored (din_ready=0); the data is not consumed.
- Changes on cmd_* while busy are ignored.

Optional Feature:
- Macro: PE_SEQUENCER_STAT_EN
- Defined: adds output stall_cnt [15:0]:
  - counts cycles in LOAD/RUN/SINGLE with din_ready=1 and din_valid=0
  - saturates at 16'hFFFF
  - cleared by rst and on each command acceptance
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles mid-RUN -> next cycle pe_mode=3, pe_activate=0, pe_in=0, busy=0, cmd_ready=1.
- LOAD len=1, din_aux=8'h05 -> one cycle later pe_mode=2, pe_filter=8'h05; done pulse in that same cycle; then pe_mode=3.
- RUN len=3, beats (data,aux)=(2,1),(3,4),(4,0) with no gaps -> three consecutive cycles pe_mode=1, pe_activate=1, pe_in=2,3,4, pe_filter=1,4,0; done with the third beat.
- RUN len=2 with a 2-cycle din_valid gap between beats -> pe_mode=3, pe_activate=0 for 2 cycles between the sa beats; pe_in/pe_filter hold; stall_cnt=2 if PE_SEQUENCER_STAT_EN.
- SINGLE len=4, data=1..4, aux=3 -> pe_mode=0 for 4 cycles, pe_in=1,2,3,4, pe_filter=3, pe_activate=0; done once.
- cmd_len=0 and cmd_op=3 -> no din_ready assertion; done 1 cycle after acceptance; pe_mode stays 3.
